bcd_countdown_timer: RTL and testbench

Parametrised BCD countdown timer for the microwave controller: keypad digits are shifted in, start/stop buttons run a pause/cancel state machine, and the count decrements once per `tick`, down to zero. It generalises the fixed m:ss down-counter to `MIN_DIGITS` minute digits and adds run/pause control, a one-cycle `done` pulse and an optional +30 s quick key. It sits between the keypad decoder and the display/magnetron control.

---
 rtl/timer_pkg.sv | 15 +
 rtl/bcd_digit_dec.sv | 26 ++
 rtl/bcd_countdown_timer.sv | 135 +++++++++++++
 tb/tb_bcd_countdown_timer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX      = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the decrement chain: wraps 0 -> WRAP and borrows onward.
module bcd_digit_dec
    import timer_pkg::*;
#(
    parameter bcd_t WRAP = BCD_MAX
) (
    input  bcd_t digit,
    input  logic borrow_in,
    output bcd_t digit_nx,
    output logic borrow_out
);

    always_comb begin
        digit_nx   = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                digit_nx   = WRAP;
                borrow_out = 1'b1;
            end else begin
                digit_nx = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// m:ss BCD countdown timer with keypad entry and run/pause/cancel control.
// Define TIMER_ADD30_EN to enable the +30 s quick key on the add30 input.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int MIN_DIGITS = 2
) (
    input  logic                    clock,
    input  logic                    clrn,
    input  logic                    tick,
    input  logic [3:0]              data,
    input  logic                    digit_valid,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    add30,
    output logic [3:0]              sec_ones,
    output logic [3:0]              sec_tens,
    output logic [4*MIN_DIGITS-1:0] mins,
    output logic                    running,
    output logic                    paused,
    output logic                    zero,
    output logic                    done
);

    // digit 0 = sec_ones, 1 = sec_tens, 2.. = minutes (LS first)
    localparam int NDIG = MIN_DIGITS + 2;

    state_e            state, state_nx;
    bcd_t [NDIG-1:0]   digs, digs_nx, dec_digs, add_digs;
    logic              done_nx;
    logic              add_hit;
    logic [NDIG:0]     brw;
    logic              brw_unused;

    assign brw[0]     = 1'b1;
    assign brw_unused = brw[NDIG];

    for (genvar g = 0; g < NDIG; g++) begin : g_dec
        bcd_digit_dec #(
            .WRAP (g == 1 ? SEC_TENS_MAX : BCD_MAX)
        ) u_dec (
            .digit      (digs[g]),
            .borrow_in  (brw[g]),
            .digit_nx   (dec_digs[g]),
            .borrow_out (brw[g+1])
        );
    end

`ifdef TIMER_ADD30_EN
    assign add_hit = add30;

    // Tens + 3 with a single -6 correction, then BCD carry ripple through minutes.
    always_comb begin
        logic [4:0] s;
        logic       c;
        add_digs = digs;
        s = {1'b0, digs[1]} + 5'd3;
        c = 1'b0;
        if (s >= 5'd6) begin
            s = s - 5'd6;
            c = 1'b1;
        end
        add_digs[1] = s[3:0];
        for (int i = 2; i < NDIG; i++) begin
            s = {1'b0, digs[i]} + {4'd0, c};
            if (s > 5'd9) begin
                s = 5'd0;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            add_digs[i] = s[3:0];
        end
        if (c) begin
            for (int i = 2; i < NDIG; i++) add_digs[i] = BCD_MAX;
            add_digs[1] = SEC_TENS_MAX;
            add_digs[0] = BCD_MAX;
        end
    end
`else
    logic add30_unused;
    assign add30_unused = add30;
    assign add_hit      = 1'b0;
    assign add_digs     = digs;
`endif

    always_comb begin
        state_nx = state;
        digs_nx  = digs;
        done_nx  = 1'b0;
        if (stop) begin
            if (state == RUN) begin
                state_nx = PAUSE;
            end else begin
                state_nx = IDLE;
                digs_nx  = '0;
            end
        end else if (add_hit) begin
            digs_nx = add_digs;
            if (state == IDLE) state_nx = RUN;
        end else if (start && state == PAUSE) begin
            state_nx = RUN;
        end else if (start && state == IDLE && !zero) begin
            state_nx = RUN;
        end else if (tick && state == RUN) begin
            digs_nx = dec_digs;
            if (dec_digs == '0) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
        end else if (digit_valid && state == IDLE && data <= BCD_MAX) begin
            digs_nx = {digs[NDIG-2:0], data};
        end
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            digs  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            digs  <= digs_nx;
            done  <= done_nx;
        end
    end

    assign sec_ones = digs[0];
    assign sec_tens = digs[1];
    assign mins     = digs[NDIG-1:2];
    assign running  = (state == RUN);
    assign paused   = (state == PAUSE);
    assign zero     = (digs == '0);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench: an integer min/sec model predicts each cycle's outputs.
module tb_bcd_countdown_timer;

    localparam int N = 2;

    logic           clock = 1'b0;
    logic           clrn  = 1'b0;
    logic           tick = 1'b0, digit_valid = 1'b0, start = 1'b0, stop = 1'b0, add30 = 1'b0;
    logic [3:0]     data = 4'd0;
    logic [3:0]     sec_ones, sec_tens;
    logic [4*N-1:0] mins;
    logic           running, paused, zero, done;

    bcd_countdown_timer #(.MIN_DIGITS(N)) dut (
        .clock(clock), .clrn(clrn), .tick(tick), .data(data), .digit_valid(digit_valid),
        .start(start), .stop(stop), .add30(add30), .sec_ones(sec_ones), .sec_tens(sec_tens),
        .mins(mins), .running(running), .paused(paused), .zero(zero), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] digs;
        logic [3:0]  flg;   // running, paused, done, zero
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    int   m_min = 0, m_sec = 0, m_st = 0;
    bit   m_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v, input int nd);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] dut_digs();
        return 32'({mins, sec_tens, sec_ones});
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.digs = (to_bcd(m_min, N) << 8) | to_bcd(m_sec, 2);
        e.flg  = {m_st == 1, m_st == 2, m_done, (m_min == 0 && m_sec == 0)};
        return e;
    endfunction

    task automatic model_step(input bit t, st, sp, a, dv, input logic [3:0] d);
        int mx;
        int v;
        mx     = 1;
        for (int i = 0; i < N; i++) mx = mx * 10;
        m_done = 1'b0;
        if (sp) begin
            if (m_st == 1) m_st = 2;
            else begin m_st = 0; m_min = 0; m_sec = 0; end
        end
`ifdef TIMER_ADD30_EN
        else if (a) begin
            if (m_sec >= 30) begin m_sec = m_sec - 30; m_min++; end
            else m_sec = m_sec + 30;
            if (m_min > mx - 1) begin m_min = mx - 1; m_sec = 59; end
            if (m_st == 0) m_st = 1;
        end
`endif
        else if (st && m_st == 2) m_st = 1;
        else if (st && m_st == 0 && (m_min != 0 || m_sec != 0)) m_st = 1;
        else if (t && m_st == 1) begin
            if (m_sec > 0) m_sec--;
            else begin m_sec = 59; m_min--; end
            if (m_min == 0 && m_sec == 0) begin m_done = 1'b1; m_st = 0; end
        end else if (dv && m_st == 0 && d <= 4'd9) begin
            v     = (m_min * 100 + m_sec) * 10 + int'(d);
            v     = v % (mx * 100);
            m_min = v / 100;
            m_sec = v % 100;
        end
    endtask

    // One clock: drive strobes, predict, then compare once the edge has passed.
    task automatic cyc(input string tag, input bit t, st, sp, a, dv, input logic [3:0] d);
        exp_t e;
        tick = t; start = st; stop = sp; add30 = a; digit_valid = dv; data = d;
        model_step(t, st, sp, a, dv, d);
        exp_q.push_back(model_exp());
        @(posedge clock);
        #1;
        tick = 1'b0; start = 1'b0; stop = 1'b0; add30 = 1'b0; digit_valid = 1'b0;
        e = exp_q.pop_front();
        chk({tag, ".digs"}, dut_digs(), e.digs);
        chk({tag, ".flags"}, {28'd0, running, paused, done, zero}, {28'd0, e.flg});
    endtask

    task automatic key(input logic [3:0] d);
        cyc("key", 0, 0, 0, 0, 1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc("idle", 0, 0, 0, 0, 0, 4'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst.digs", dut_digs(), 32'h0);
        chk("rst.flags", {28'd0, running, paused, done, zero}, 32'h1);
        clrn = 1'b1;
        @(posedge clock);
        #1;

        // entry 1,3,0 -> 1:30; key 0xC ignored
        key(4'd1); key(4'd3); key(4'd0); key(4'hC);
        chk("entry.130", dut_digs(), 32'h0130);
        cyc("idle_stop", 0, 0, 1, 0, 0, 0);

        // 0:02 countdown to done
        key(4'd2);
        cyc("start", 0, 1, 0, 0, 0, 0);
        cyc("tick", 1, 0, 0, 0, 0, 0);
        cyc("tick", 1, 0, 0, 0, 0, 0);
        chk("expire.done", {31'd0, done}, 32'd1);
        idle(2);

        // pause / resume / cancel at 1:00
        key(4'd1); key(4'd0); key(4'd0);
        cyc("start", 0, 1, 0, 0, 0, 0);
        cyc("pause", 0, 0, 1, 0, 0, 0);
        cyc("ptick", 1, 0, 0, 0, 0, 0);
        cyc("ptick", 1, 0, 0, 0, 0, 0);
        cyc("pkey", 0, 0, 0, 0, 1, 4'd7);
        cyc("resume", 0, 1, 0, 0, 0, 0);
        cyc("tick", 1, 0, 0, 0, 0, 0);
        chk("resume.059", dut_digs(), 32'h0059);
        cyc("rkey", 0, 0, 0, 0, 1, 4'd3);
        cyc("pause", 0, 0, 1, 0, 0, 0);
        cyc("cancel", 0, 0, 1, 0, 0, 0);

        // 10:00 -> 09:59
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        cyc("start", 0, 1, 0, 0, 0, 0);
        cyc("tick", 1, 0, 0, 0, 0, 0);
        chk("borrow.0959", dut_digs(), 32'h0959);
        cyc("pause", 0, 0, 1, 0, 0, 0);
        cyc("cancel", 0, 0, 1, 0, 0, 0);

        // 0:90 runs 90 back-to-back ticks
        key(4'd9); key(4'd0);
        cyc("start", 0, 1, 0, 0, 0, 0);
        cyc("tick90", 1, 0, 0, 0, 0, 0);
        chk("s90.089", dut_digs(), 32'h0089);
        for (int i = 0; i < 89; i++) cyc("tick90", 1, 0, 0, 0, 0, 0);
        idle(1);

        // stop beats tick at 0:05
        key(4'd5);
        cyc("start", 0, 1, 0, 0, 0, 0);
        cyc("stop_tick", 1, 0, 1, 0, 0, 0);
        chk("conflict.paused", {31'd0, paused}, 32'd1);
        cyc("cancel", 0, 0, 1, 0, 0, 0);

        // start with zero count stays IDLE
        cyc("start_zero", 0, 1, 0, 0, 0, 0);

        // add30 cases (effective only with the macro; the model follows suit)
        cyc("add30_zero", 0, 0, 0, 1, 0, 0);
        cyc("stop", 0, 0, 1, 0, 0, 0);
        cyc("stop", 0, 0, 1, 0, 0, 0);
        key(4'd4); key(4'd5);
        cyc("add30_045", 0, 0, 0, 1, 0, 0);
        cyc("stop", 0, 0, 1, 0, 0, 0);
        cyc("stop", 0, 0, 1, 0, 0, 0);
        key(4'd9); key(4'd9); key(4'd4); key(4'd5);
        cyc("add30_sat", 0, 0, 0, 1, 0, 0);
        cyc("stop", 0, 0, 1, 0, 0, 0);
        cyc("stop", 0, 0, 1, 0, 0, 0);

        // async reset mid-RUN: immediate clear, no done afterwards
        key(4'd2); key(4'd5);
        cyc("start", 0, 1, 0, 0, 0, 0);
        cyc("tick", 1, 0, 0, 0, 0, 0);
        #2 clrn = 1'b0;
        #1;
        chk("arst.digs", dut_digs(), 32'h0);
        chk("arst.flags", {28'd0, running, paused, done, zero}, 32'h1);
        m_min = 0; m_sec = 0; m_st = 0; m_done = 1'b0;
        #2 clrn = 1'b1;
        @(posedge clock);
        #1;
        cyc("post_rst", 1, 0, 0, 0, 0, 0);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
